// File: rtl/mask_video_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mask_video_gen: raster timing + synthetic binary-mask pixel source.    |
// | Optional LFSR salt-and-pepper noise with `define NOISE_INJECT_EN. Rev 1.0 |
// +------------------------------------------------------------------------+
module mask_video_gen #(
  parameter int H_ACTIVE = 64,
  parameter int H_FP     = 4,
  parameter int H_SYNC   = 8,
  parameter int H_BP     = 7,
  parameter int V_ACTIVE = 64,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 2,
  parameter int BLK_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [7:0]  noise_thr,
  output logic        de_out,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic [23:0] pixel_out,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_RECT_LO = HW'(H_ACTIVE / 4);
  localparam logic [HW-1:0] H_RECT_HI = HW'((3 * H_ACTIVE) / 4);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_RECT_LO = VW'(V_ACTIVE / 4);
  localparam logic [VW-1:0] V_RECT_HI = VW'((3 * V_ACTIVE) / 4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [1:0]    pat_q, pat_d;
  logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic          mask_q, mask_d, fs_q, fs_d;

  logic          h_last, v_last, frame_end, at_origin, running, active_px;
  logic [1:0]    pat_cur;
  logic          pat_mask;
  logic          noise_hit;

  // Position decode for the pixel the counters currently point at.
  always_comb begin
    h_last    = (h_cnt_q == H_LAST);
    v_last    = (v_cnt_q == V_LAST);
    frame_end = h_last && v_last;
    at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
    running   = (state_q != S_IDLE);
    active_px = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    pat_cur   = at_origin ? pattern_sel : pat_q;
    pat_mask  = 1'b0;
    case (pat_cur)
      2'd0:    pat_mask = 1'b0;
      2'd1:    pat_mask = 1'b1;
      2'd2:    pat_mask = h_cnt_q[BLK_LOG2] ^ v_cnt_q[BLK_LOG2];
      default: pat_mask = (h_cnt_q >= H_RECT_LO) && (h_cnt_q < H_RECT_HI) &&
                          (v_cnt_q >= V_RECT_LO) && (v_cnt_q < V_RECT_HI);
    endcase
  end

`ifdef NOISE_INJECT_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] lfsr_q, lfsr_d, lfsr_cur;
  logic [7:0]  thr_q, thr_d, thr_cur;

  // Seed is forced at the origin so every frame carries the same noise field.
  always_comb begin
    lfsr_cur  = at_origin ? LFSR_SEED : lfsr_q;
    thr_cur   = at_origin ? noise_thr : thr_q;
    noise_hit = (lfsr_cur[7:0] < thr_cur);
    lfsr_d    = lfsr_q;
    thr_d     = thr_q;
    if (running) begin
      thr_d  = thr_cur;
      lfsr_d = active_px ? {lfsr_cur[0] ^ lfsr_cur[2] ^ lfsr_cur[3] ^ lfsr_cur[5],
                            lfsr_cur[15:1]}
                         : lfsr_cur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
      thr_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      thr_q  <= thr_d;
    end
  end
`else
  logic unused_noise_thr;
  assign noise_hit        = 1'b0;
  assign unused_noise_thr = ^noise_thr;
`endif

  always_comb begin
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    pat_d       = pat_q;
    de_d        = 1'b0;
    hs_d        = 1'b0;
    vs_d        = 1'b0;
    mask_d      = 1'b0;
    fs_d        = 1'b0;

    case (state_q)
      S_IDLE:  if (enable) state_d = S_RUN;
      S_RUN:   if (!enable) state_d = frame_end ? S_IDLE : S_DRAIN;
      S_DRAIN: begin
        if (enable)         state_d = S_RUN;
        else if (frame_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // IDLE keeps the counters parked at the origin so restart is immediate.
    if (running) begin
      h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
      if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
      if (frame_end) frame_cnt_d = frame_cnt_q + 16'd1;
      pat_d  = pat_cur;
      de_d   = active_px;
      hs_d   = (h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END);
      vs_d   = (v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END);
      mask_d = active_px && (pat_mask ^ noise_hit);
      fs_d   = at_origin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      pat_q       <= '0;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      mask_q      <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      pat_q       <= pat_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      mask_q      <= mask_d;
      fs_q        <= fs_d;
    end
  end

  assign de_out      = de_q;
  assign h_sync_out  = hs_q;
  assign v_sync_out  = vs_q;
  assign pixel_out   = {24{mask_q}};
  assign frame_start = fs_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mask_video_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mask_video_gen: directed scoreboard bench for mask_video_gen.       |
// | Noise checks are compiled in with `define NOISE_INJECT_EN. Rev 1.0     |
// +------------------------------------------------------------------------+
module tb_mask_video_gen;

`ifdef NOISE_INJECT_EN
  localparam logic [7:0] NTHR = 8'd0;
`else
  localparam logic [7:0] NTHR = 8'd128;  // must be ignored without noise
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [7:0]  noise_thr;
  logic        de_out, h_sync_out, v_sync_out, frame_start;
  logic [23:0] pixel_out;
  logic [15:0] frame_cnt;

  mask_video_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .noise_thr   (noise_thr),
    .de_out      (de_out),
    .h_sync_out  (h_sync_out),
    .v_sync_out  (v_sync_out),
    .pixel_out   (pixel_out),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];
  logic [63:0] cap [2][64];

  // monitor state
  int cyc = 0, fs_cnt = 0, t_fs0 = 0, t_fs1 = 0;
  int de_tot = 0, hs_tot = 0, vs_tot = 0;
  int de_rises = 0, t_de0 = 0, t_de1 = 0, de_run0 = 0;
  int hs_rises = 0, t_hs0 = 0, hs_run0 = 0;
  int px = 0, cap_req = 0, cap_done = 0, cap_sel = 0, cap_line = 0;
  logic cap_mode = 1'b0, prev_de = 1'b0, prev_hs = 1'b0, bad = 1'b0;
  logic [63:0] acc = '0;
  logic [63:0] e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_fs(input int budget, input string name);
    int k = 0;
    tick(1);
    while (frame_start !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    chk(name, {31'd0, frame_start}, 32'd1);
  endtask

  function automatic logic [63:0] exp_line(input int pat, input int y);
    logic [63:0] w = '0;
    for (int x = 0; x < 64; x++) begin
      case (pat)
        1:       w[x] = 1'b1;
        2:       w[x] = (((x / 8) + (y / 8)) % 2) == 1;
        3:       w[x] = (x >= 16) && (x < 48) && (y >= 16) && (y < 48);
        default: w[x] = 1'b0;
      endcase
    end
    return w;
  endfunction

  task automatic push_frame(input int pat);
    for (int y = 0; y < 64; y++) exp_q.push_back(exp_line(pat, y));
  endtask

  // Monitor: timing statistics for the first frame, line-level scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        px = 0; bad = 1'b0; acc = '0; prev_de = 1'b0; prev_hs = 1'b0;
      end else begin
        if (frame_start) begin
          fs_cnt++;
          if (fs_cnt == 1) t_fs0 = cyc;
          else if (fs_cnt == 2) t_fs1 = cyc;
          cap_line = 0;
          if (cap_req > 0) begin
            cap_mode = 1'b1; cap_sel = cap_done; cap_done++; cap_req--;
          end else cap_mode = 1'b0;
        end
        if (fs_cnt == 1) begin
          if (de_out) de_tot++;
          if (h_sync_out) hs_tot++;
          if (v_sync_out) vs_tot++;
          if (de_out && !prev_de) begin
            de_rises++;
            if (de_rises == 1) t_de0 = cyc;
            else if (de_rises == 2) t_de1 = cyc;
          end
          if (de_out && de_rises == 1) de_run0++;
          if (h_sync_out && !prev_hs) begin
            hs_rises++;
            if (hs_rises == 1) t_hs0 = cyc;
          end
          if (h_sync_out && hs_rises == 1) hs_run0++;
        end
        if (de_out) begin
          if (px < 64) acc[px] = (pixel_out == 24'hFFFFFF);
          if (pixel_out != 24'h000000 && pixel_out != 24'hFFFFFF) bad = 1'b1;
          px++;
        end else if (prev_de) begin
          if (cap_mode) begin
            if (cap_line < 64) cap[cap_sel][cap_line] = acc;
            cap_line++;
          end else if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL sb_unexpected_line: got line mask %h, expected no active line", acc);
          end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (px != 64 || bad || acc !== e) begin
              n_errors++;
              $display("FAIL sb_line: got %0d px mask %h mixed=%0b, expected 64 px mask %h",
                       px, acc, bad, e);
            end
          end
          px = 0; bad = 1'b0; acc = '0;
        end
        prev_de = de_out;
        prev_hs = h_sync_out;
      end
    end
  end

  initial begin
    int k;
    int busy;
    rst_n = 1'b0; enable = 1'b1; pattern_sel = 2'd2; noise_thr = NTHR;
    tick(3);
    chk("rst_de", {31'd0, de_out}, 0);
    chk("rst_hsync", {31'd0, h_sync_out}, 0);
    chk("rst_vsync", {31'd0, v_sync_out}, 0);
    chk("rst_pixel", {8'd0, pixel_out}, 0);
    chk("rst_fs", {31'd0, frame_start}, 0);
    chk("rst_fcnt", {16'd0, frame_cnt}, 0);

    // Frame A: checkerboard; switching to rectangle mid-frame hits frame B.
    push_frame(2);
    rst_n = 1'b1;
    tick(1);
    chk("de_after_sample", {31'd0, de_out}, 0);
    tick(1);
    chk("de_first", {31'd0, de_out}, 1);
    chk("fs_first", {31'd0, frame_start}, 1);
    pattern_sel = 2'd3;
    push_frame(3);

    wait_fs(6000, "fs_frame_b");
    chk("de_total", de_tot, 4096);
    chk("de_run_line0", de_run0, 64);
    chk("line_period", t_de1 - t_de0, 83);
    chk("hs_offset", t_hs0 - t_de0, 68);
    chk("hs_width", hs_run0, 8);
    chk("hs_total", hs_tot, 560);
    chk("vs_total", vs_tot, 166);
    chk("frame_period", t_fs1 - t_fs0, 5810);
    chk("fcnt_b", {16'd0, frame_cnt}, 1);

    // Frame B stays rectangle; pattern 0 takes effect at frame C.
    tick(83 * 30);
    pattern_sel = 2'd0;
    push_frame(0);

    wait_fs(6000, "fs_frame_c");
    chk("fcnt_c", {16'd0, frame_cnt}, 2);
    tick(83 * 10);
    enable = 1'b0;
    k = 83 * 10;
    while (frame_cnt !== 16'd3 && k < 7000) begin
      tick(1);
      k++;
    end
    chk("drain_len", k, 5809);
    busy = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (de_out || h_sync_out || v_sync_out || frame_start || (pixel_out != 24'd0)) busy++;
    end
    chk("idle_quiet", busy, 0);
    chk("fcnt_idle", {16'd0, frame_cnt}, 3);
    chk("sb_drained", exp_q.size(), 0);

    // Frame D: re-enable, all-ones, then reset mid-frame.
    pattern_sel = 2'd1;
    push_frame(1);
    enable = 1'b1;
    tick(1);
    chk("fs_reen_sample", {31'd0, frame_start}, 0);
    tick(1);
    chk("fs_reen", {31'd0, frame_start}, 1);
    chk("fcnt_reen", {16'd0, frame_cnt}, 3);
    tick(83 * 20 + 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_de", {31'd0, de_out}, 0);
    chk("midrst_pixel", {8'd0, pixel_out}, 0);
    chk("midrst_fcnt", {16'd0, frame_cnt}, 0);
    tick(3);
    exp_q.delete();
    chk("midrst_hold_fs", {31'd0, frame_start}, 0);

`ifdef NOISE_INJECT_EN
    pattern_sel = 2'd0;
    noise_thr = 8'd0;
    push_frame(0);
    rst_n = 1'b1;
    wait_fs(10, "fs_noise0");
    noise_thr = 8'd128;
    cap_req = 2;
    wait_fs(6000, "fs_noise1");
    wait_fs(6000, "fs_noise2");
    enable = 1'b0;
    k = 0;
    while (frame_cnt !== 16'd3 && k < 7000) begin
      tick(1);
      k++;
    end
    chk("noise_fcnt", {16'd0, frame_cnt}, 3);
    tick(5);
    chk("noise_sb_empty", exp_q.size(), 0);
    chk("noise_cap_frames", cap_done, 2);
    chk("noise_cap_lines", cap_line, 64);
    begin
      int ones = 0;
      int diff = 0;
      for (int y = 0; y < 64; y++) begin
        ones += $countones(cap[0][y]);
        if (cap[0][y] !== cap[1][y]) diff++;
      end
      n_checks++;
      if (ones < 1600 || ones > 2496) begin
        n_errors++;
        $display("FAIL noise_density: got %0d mask=1 pixels, expected 1600..2496", ones);
      end
      chk("noise_repeat_diff_lines", diff, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
